// File: rtl/binned_memory_reader_if.sv
// ---------------------------------------------------------------------------
// binned_memory_reader_if
//   Bus bundle between the binned memory reader, the binned stub memory read
//   port and the downstream stream consumer.
//
//   Memory read port : addrb, enb, regceb (reader -> memory), doutb (memory ->
//                      reader).
//   Output stream    : dout, dout_bin, dout_slot, dout_valid (reader ->
//                      consumer), dout_ready (consumer -> reader).
//
//   master : the reader side.
//   slave  : the memory plus downstream consumer side.
// ---------------------------------------------------------------------------
interface binned_memory_reader_if #(
  parameter int RAM_WIDTH  = 14,
  parameter int AW         = 9,
  parameter int BW         = 3,
  parameter int NENT_WIDTH = 4
);
  // Memory read port
  logic [AW-1:0]         addrb;
  logic                  enb;
  logic                  regceb;
  logic [RAM_WIDTH-1:0]  doutb;

  // Output stream
  logic [RAM_WIDTH-1:0]  dout;
  logic [BW-1:0]         dout_bin;
  logic [NENT_WIDTH-1:0] dout_slot;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    output addrb, enb, regceb,
    input  doutb,
    output dout, dout_bin, dout_slot, dout_valid,
    input  dout_ready
  );

  modport slave (
    input  addrb, enb, regceb,
    output doutb,
    input  dout, dout_bin, dout_slot, dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/binned_memory_reader.sv
// ---------------------------------------------------------------------------
// binned_memory_reader
//   Read-side sequencer for the paged, binned stub memory. A start pulse
//   latches one page number and its per-bin entry counts; the sequencer then
//   walks bins 0..NBINS-1 and, inside each bin, slots 0..nent-1, issuing at
//   most one read per cycle. Returned words are re-tagged with their bin/slot
//   and delivered as a valid/ready stream through a small skid FIFO.
//
// Ports
//   clkb     in   clock (memory read clock)
//   rstb     in   synchronous active-high reset
//   start    in   single-cycle request to read one page
//   page_i   in   page number, sampled with start
//   nent_i   in   NBINS packed entry counts, bin k at [k*NENT_WIDTH +: NENT_WIDTH]
//   bus      -    master side of binned_memory_reader_if (memory read port
//                 and output stream)
//   busy     out  high from the cycle after an accepted start until done
//   done     out  single-cycle pulse once the page is fully delivered
//
// FIFO_DEPTH must be at least L+1, where L is the memory read latency.
// ---------------------------------------------------------------------------
module binned_memory_reader #(
  parameter int    RAM_WIDTH       = 14,
  parameter int    NPAGES          = 4,
  parameter int    NBINS           = 8,
  parameter int    NENT_WIDTH      = 4,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter int    FIFO_DEPTH      = 4,
  localparam int   PW              = $clog2(NPAGES),
  localparam int   BW              = $clog2(NBINS)
) (
  input  logic                        clkb,
  input  logic                        rstb,
  input  logic                        start,
  input  logic [PW-1:0]               page_i,
  input  logic [NBINS*NENT_WIDTH-1:0] nent_i,
  binned_memory_reader_if.master      bus,
  output logic                        busy,
  output logic                        done
);

  // Read latency of the memory: the output register adds one cycle.
  localparam int L    = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW   = FCW + 1;
  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_e;

  // Tag travelling alongside a read while the memory works on it.
  typedef struct packed {
    logic                  valid;
    logic [BW-1:0]         bin;
    logic [NENT_WIDTH-1:0] slot;
  } tag_t;

  typedef struct packed {
    logic [RAM_WIDTH-1:0]  data;
    logic [BW-1:0]         bin;
    logic [NENT_WIDTH-1:0] slot;
  } entry_t;

  state_e                state_q;
  logic [PW-1:0]         page_q;
  logic [NENT_WIDTH-1:0] nent_q [NBINS];
  logic [BW-1:0]         bin_q;
  logic [NENT_WIDTH-1:0] slot_q;
  logic                  busy_q;
  logic                  done_q;

  tag_t                  pipe_q [L];

  entry_t                fifo_mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]       wr_ptr_q;
  logic [PTRW-1:0]       rd_ptr_q;
  logic [FCW-1:0]        fifo_cnt_q;
  logic [FCW-1:0]        fifo_cnt_d;

  logic [CW-1:0]         inflight;
  logic [NENT_WIDTH-1:0] cur_nent;
  logic                  credit;
  logic                  rd_en;
  logic                  slot_last;
  logic                  bin_step;
  logic                  push;
  logic                  pop;
  logic                  drain_done;
  entry_t                head;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // Scan decisions
  // -------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional logic, otherwise synthesis infers a latch.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < L; k++) begin
      inflight = inflight + CW'(pipe_q[k].valid);
    end
  end

  assign cur_nent  = nent_q[bin_q];

  // Reads on the port, in the memory and in the FIFO never exceed the FIFO
  // depth, so backpressure can never overflow the FIFO.
  assign credit    = ({1'b0, fifo_cnt_q} + inflight) < CW'(FIFO_DEPTH);
  assign rd_en     = (state_q == SCAN) && (cur_nent != '0) && credit;
  assign slot_last = (slot_q == cur_nent - 1'b1);

  // Empty bins are stepped over one per cycle; a non-empty bin is left
  // after its last slot has been read.
  assign bin_step  = (state_q == SCAN) && ((cur_nent == '0) || (credit && slot_last));

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  assign push = pipe_q[L-1].valid;
  assign pop  = (fifo_cnt_q != '0) && bus.dout_ready;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Done may be scheduled while the last word is being popped this cycle.
  assign drain_done = (state_q == DRAIN) && (inflight == '0) &&
                      ((fifo_cnt_q == '0) || ((fifo_cnt_q == FCW'(1)) && pop));

  // -------------------------------------------------------------------------
  // Sequencer, read-tag pipe and FIFO pointers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q    <= IDLE;
      page_q     <= '0;
      bin_q      <= '0;
      slot_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int k = 0; k < NBINS; k++) nent_q[k] <= '0;
      for (int k = 0; k < L; k++)     pipe_q[k] <= '0;
    end else begin
      done_q <= 1'b0;

      pipe_q[0] <= tag_t'{valid: rd_en, bin: bin_q, slot: slot_q};
      for (int k = 1; k < L; k++) pipe_q[k] <= pipe_q[k-1];

      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_d;

      unique case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old run.
          if (start && !done_q) begin
            page_q  <= page_i;
            bin_q   <= '0;
            slot_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
            for (int k = 0; k < NBINS; k++) begin
              nent_q[k] <= nent_i[k*NENT_WIDTH +: NENT_WIDTH];
            end
          end
        end

        SCAN: begin
          if (rd_en) slot_q <= slot_last ? '0 : slot_q + 1'b1;
          if (bin_step) begin
            if (bin_q == BW'(NBINS - 1)) state_q <= DRAIN;
            else                         bin_q   <= bin_q + 1'b1;
          end
        end

        DRAIN: begin
          if (drain_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately left out of reset; the occupancy
  // count is reset and the output is gated by it, so stale entries are never
  // observed.
  always_ff @(posedge clkb) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= entry_t'{data: bus.doutb,
                                       bin:  pipe_q[L-1].bin,
                                       slot: pipe_q[L-1].slot};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign head           = fifo_mem_q[rd_ptr_q];

  assign bus.addrb      = {page_q, bin_q, slot_q};
  assign bus.enb        = rd_en;
  assign bus.regceb     = 1'b1;

  assign bus.dout_valid = (fifo_cnt_q != '0);
  assign bus.dout       = bus.dout_valid ? head.data : '0;
  assign bus.dout_bin   = bus.dout_valid ? head.bin  : '0;
  assign bus.dout_slot  = bus.dout_valid ? head.slot : '0;

  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_binned_memory_reader.sv
// ---------------------------------------------------------------------------
// tb_binned_memory_reader
//   Two readers side by side, one per memory latency setting, share the same
//   request stimulus and dout_ready. Each has its own behavioural memory.
//   Expected read addresses and stream words come from a reference model
//   that enumerates (bin, slot) pairs directly from the entry counts.
// ---------------------------------------------------------------------------
module tb_binned_memory_reader;

  typedef struct packed {
    logic [13:0] data;
    logic [2:0]  bin;
    logic [3:0]  slot;
  } word_t;

  localparam logic [34:0] RST_VEC = 35'h1;     // only regceb is high
  localparam logic [31:0] CASE1   = 32'h2000_1003;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  page;
  logic [31:0] nent;
  logic        ready;
  logic        clr_mon;
  int          cyc = 0;
  int          start_cyc;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [13:0] mem [512];
  word_t       exp_w [$];
  logic [8:0]  exp_a [$];

  logic        busy_w [2];
  logic        done_w [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binned_memory_reader_if bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    binned_memory_reader #(
      .RAM_PERFORMANCE((g == 0) ? "HIGH_PERFORMANCE" : "LOW_LATENCY")
    ) u_dut (
      .clkb   (clk),
      .rstb   (rst),
      .start  (start),
      .page_i (page),
      .nent_i (nent),
      .bus    (bus[g]),
      .busy   (busy_w[g]),
      .done   (done_w[g])
    );

    assign bus[g].dout_ready = ready;

    // Behavioural memory: g=0 has an output register (2-cycle read).
    if (g == 0) begin : g_mem
      logic [13:0] r1;
      always @(posedge clk) begin
        if (bus[g].enb)    r1 <= mem[bus[g].addrb];
        if (bus[g].regceb) bus[g].doutb <= r1;
      end
    end else begin : g_mem
      always @(posedge clk) begin
        if (bus[g].enb) bus[g].doutb <= mem[bus[g].addrb];
      end
    end

    // Monitor: collects reads, accepted words, done pulses and the number
    // of reads issued but not yet accepted downstream.
    word_t      got [$];
    logic [8:0] addrs [$];
    int n_done = 0, done_cyc = -1, n_valid = 0;
    int outst = 0, max_outst = 0, first_en = -1, first_valid = -1;

    always @(negedge clk) begin
      if (clr_mon) begin
        got.delete();
        addrs.delete();
        n_done = 0; done_cyc = -1; n_valid = 0;
        outst = 0; max_outst = 0; first_en = -1; first_valid = -1;
      end else begin
        if (bus[g].enb) begin
          addrs.push_back(bus[g].addrb);
          outst++;
          if (first_en < 0) first_en = cyc;
        end
        if (bus[g].dout_valid) begin
          n_valid++;
          if (first_valid < 0) first_valid = cyc;
        end
        if (bus[g].dout_valid && bus[g].dout_ready) begin
          got.push_back({bus[g].dout, bus[g].dout_bin, bus[g].dout_slot});
          outst--;
        end
        if (outst > max_outst) max_outst = outst;
        if (done_w[g]) begin
          n_done++;
          done_cyc = cyc;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: bins ascending, slots 0..count-1, address {page,bin,slot}.
  task automatic build_exp(input int pg, input logic [31:0] ne);
    int n;
    int a;
    exp_w.delete();
    exp_a.delete();
    for (int b = 0; b < 8; b++) begin
      n = int'(ne[4*b +: 4]);
      for (int s = 0; s < n; s++) begin
        a = pg * 128 + b * 16 + s;
        exp_a.push_back(9'(a));
        exp_w.push_back({mem[a], 3'(b), 4'(s)});
      end
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1 clr_mon = 1'b1;
    @(posedge clk); #1 clr_mon = 1'b0;
  endtask

  task automatic start_page(input logic [1:0] pg, input logic [31:0] ne);
    @(posedge clk); #1;
    page = pg; nent = ne; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done on both readers; optionally randomises dout_ready and
  // fires a second start on iteration restart_at.
  task automatic wait_done(input string tag, input bit rnd, input int restart_at);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == restart_at) begin
        page = 2'd3; nent = 32'h0505_0505; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (rnd) ready = 1'($urandom_range(0, 1));
      if (g_dut[0].n_done > 0 && g_dut[1].n_done > 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check({tag, " done seen"}, 64'(ok), 64'd1);
  endtask

  task automatic cmp_stream(input string tag, input word_t got[$], input logic [8:0] adr[$]);
    check({tag, " word count"}, 64'(got.size()), 64'(exp_w.size()));
    for (int i = 0; i < got.size() && i < exp_w.size(); i++)
      check($sformatf("%s word%0d", tag, i), 64'(got[i]), 64'(exp_w[i]));
    check({tag, " read count"}, 64'(adr.size()), 64'(exp_a.size()));
    for (int i = 0; i < adr.size() && i < exp_a.size(); i++)
      check($sformatf("%s addr%0d", tag, i), 64'(adr[i]), 64'(exp_a[i]));
  endtask

  task automatic post_run(input string tag);
    cmp_stream({tag, "/hp"}, g_dut[0].got, g_dut[0].addrs);
    cmp_stream({tag, "/ll"}, g_dut[1].got, g_dut[1].addrs);
    check({tag, "/hp done pulses"}, 64'(g_dut[0].n_done), 64'd1);
    check({tag, "/ll done pulses"}, 64'(g_dut[1].n_done), 64'd1);
    check({tag, "/hp outstanding<=4"}, 64'(g_dut[0].max_outst <= 4), 64'd1);
    check({tag, "/ll outstanding<=4"}, 64'(g_dut[1].max_outst <= 4), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/hp outputs"},
          64'({bus[0].enb, bus[0].addrb, bus[0].dout_valid, bus[0].dout, bus[0].dout_bin,
               bus[0].dout_slot, busy_w[0], done_w[0], bus[0].regceb}), 64'(RST_VEC));
    check({tag, "/ll outputs"},
          64'({bus[1].enb, bus[1].addrb, bus[1].dout_valid, bus[1].dout, bus[1].dout_bin,
               bus[1].dout_slot, busy_w[1], done_w[1], bus[1].regceb}), 64'(RST_VEC));
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Directed and randomised sequence
  // -------------------------------------------------------------------------
  initial begin
    bit          hit;
    int          rpg;
    logic [31:0] rne;

    rst = 1'b1; clr_mon = 1'b1; start = 1'b0; page = '0; nent = '0; ready = 1'b1;
    for (int a = 0; a < 512; a++) mem[a] = 14'(a);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; clr_mon = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset");

    // 1: mixed bins, continuous ready
    build_exp(2, CASE1);
    clear_mon();
    start_page(2'd2, CASE1);
    wait_done("t1", 1'b0, -1);
    post_run("t1");
    check("t1/hp first valid latency", 64'(g_dut[0].first_valid - g_dut[0].first_en), 64'd3);
    check("t1/ll first valid latency", 64'(g_dut[1].first_valid - g_dut[1].first_en), 64'd2);

    // 2: all bins empty
    build_exp(1, 32'h0);
    clear_mon();
    start_page(2'd1, 32'h0);
    wait_done("t2", 1'b0, -1);
    post_run("t2");
    check("t2/hp done latency", 64'(g_dut[0].done_cyc - start_cyc), 64'd10);
    check("t2/ll done latency", 64'(g_dut[1].done_cyc - start_cyc), 64'd10);
    check("t2/hp valid cycles", 64'(g_dut[0].n_valid), 64'd0);
    check("t2/ll valid cycles", 64'(g_dut[1].n_valid), 64'd0);

    // 3: full bin under backpressure
    build_exp(0, 32'h00F0_0000);
    clear_mon();
    ready = 1'b0;
    start_page(2'd0, 32'h00F0_0000);
    repeat (20) @(posedge clk);
    #1;
    check("t3/hp reads while stalled", 64'(g_dut[0].addrs.size()), 64'd4);
    check("t3/ll reads while stalled", 64'(g_dut[1].addrs.size()), 64'd4);
    check("t3/hp words while stalled", 64'(g_dut[0].got.size()), 64'd0);
    check("t3/ll words while stalled", 64'(g_dut[1].got.size()), 64'd0);
    ready = 1'b1;
    wait_done("t3", 1'b0, -1);
    post_run("t3");

    // 4: case 1 with random backpressure
    build_exp(2, CASE1);
    clear_mon();
    start_page(2'd2, CASE1);
    wait_done("t4", 1'b1, -1);
    post_run("t4");

    // 5: second start while busy is ignored
    build_exp(2, CASE1);
    clear_mon();
    start_page(2'd2, CASE1);
    wait_done("t5", 1'b0, 3);
    post_run("t5");

    // 6: reset mid-run, then a fresh page
    clear_mon();
    hit = 1'b0;
    start_page(2'd2, CASE1);
    for (int i = 0; i < 40; i++) begin
      if (g_dut[0].addrs.size() >= 3) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("t6 third read seen", 64'(hit), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t6 reset");
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("t6/hp no done after reset", 64'(g_dut[0].n_done), 64'd0);
    check("t6/ll no done after reset", 64'(g_dut[1].n_done), 64'd0);
    build_exp(3, CASE1);
    clear_mon();
    start_page(2'd3, CASE1);
    wait_done("t6b", 1'b0, -1);
    post_run("t6b");

    // Randomised pages, counts, memory contents and backpressure
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 512; a++) mem[a] = 14'($urandom);
      rpg = int'($urandom_range(0, 3));
      rne = $urandom;
      build_exp(rpg, rne);
      clear_mon();
      start_page(2'(rpg), rne);
      wait_done($sformatf("rnd%0d", r), 1'b1, -1);
      post_run($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
